// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and
// holds the IF/ID register feeding the branch-target adder (offset + pc+8).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [23:0] if_id_offset,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    DRAIN      = 2'd2
  } stateT;

  stateT       state;
  logic [31:0] pc;
  logic [31:0] savedTarget;
  logic        reqQ;
  logic [31:0] instrQ;
  logic [31:0] ifPcQ;
  logic        validQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_HOLD;
      pc          <= RESET_PC;
      savedTarget <= 32'h0;
      reqQ        <= 1'b0;
      instrQ      <= NOP_INSTR;
      ifPcQ       <= 32'h0;
      validQ      <= 1'b0;
    end else begin
      case (state)
        RESET_HOLD: begin
          state  <= FETCH;
          reqQ   <= 1'b1;
          instrQ <= NOP_INSTR;
          validQ <= 1'b0;
        end
        FETCH: begin
          if (branch_taken) begin
            // Branch beats stall; a pending request must finish before redirect.
            instrQ <= NOP_INSTR;
            validQ <= 1'b0;
            if (imem_ready) begin
              pc <= branch_target;
            end else begin
              savedTarget <= branch_target;
              state       <= DRAIN;
            end
          end else if (imem_ready) begin
            if (!stall) begin
              instrQ <= imem_data;
              ifPcQ  <= pc + 32'd8;
              validQ <= 1'b1;
              pc     <= pc + 32'd4;
            end
          end else if (!stall) begin
            instrQ <= NOP_INSTR;
            validQ <= 1'b0;
          end
        end
        DRAIN: begin
          // Address stays on the old pc until memory completes; the latest target wins.
          if (branch_taken) begin
            savedTarget <= branch_target;
          end
          if (imem_ready) begin
            pc    <= branch_taken ? branch_target : savedTarget;
            state <= FETCH;
          end
        end
        default: begin
          state <= RESET_HOLD;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr    = pc;
  assign imem_req     = reqQ;
  assign if_id_instr  = instrQ;
  assign if_id_pc     = ifPcQ;
  assign if_id_valid  = validQ;
  assign if_id_offset = instrQ[23:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imemReady;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;

  logic [31:0] imemAddr, imemData, ifIdInstr, ifIdPc;
  logic [23:0] ifIdOffset;
  logic        imemReq, ifIdValid;

  logic [31:0] wAddr, wData, wInstr, wPc;
  logic [23:0] wOffset;
  logic        wReq, wValid;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        mHold;
  logic        mDrain;
  logic [31:0] mSaved;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mIfPc;
  logic        mValid;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hE000_0000 | a;
  endfunction

  assign imemData = memWord(imemAddr);
  assign wData    = memWord(wAddr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imemAddr), .imem_req(imemReq),
    .imem_data(imemData), .imem_ready(imemReady),
    .stall(stall), .branch_taken(branchTaken), .branch_target(branchTarget),
    .if_id_instr(ifIdInstr), .if_id_pc(ifIdPc),
    .if_id_offset(ifIdOffset), .if_id_valid(ifIdValid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dutW (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(wAddr), .imem_req(wReq),
    .imem_data(wData), .imem_ready(imemReady),
    .stall(stall), .branch_taken(branchTaken), .branch_target(branchTarget),
    .if_id_instr(wInstr), .if_id_pc(wPc),
    .if_id_offset(wOffset), .if_id_valid(wValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mHold = 1'b1; mDrain = 1'b0; mSaved = 32'h0; mPc = 32'h0;
    mInstr = 32'h0; mIfPc = 32'h0; mValid = 1'b0;
  endtask

  // One clock edge of the fetch stage, written as request/response rules.
  task automatic modelStep(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    if (mHold) begin
      mHold = 1'b0;
    end else if (mDrain) begin
      if (br) mSaved = tgt;
      if (rdy) begin
        mPc = mSaved;
        mDrain = 1'b0;
      end
    end else if (br) begin
      mInstr = 32'h0; mValid = 1'b0;
      if (rdy) mPc = tgt;
      else begin
        mSaved = tgt;
        mDrain = 1'b1;
      end
    end else if (rdy) begin
      if (!stl) begin
        mInstr = memWord(mPc);
        mIfPc  = mPc + 32'd8;
        mValid = 1'b1;
        mPc    = mPc + 32'd4;
      end
    end else if (!stl) begin
      mInstr = 32'h0; mValid = 1'b0;
    end
  endtask

  task automatic checkAll(input string ctx);
    chk({ctx, ".req"},    {31'h0, imemReq},   {31'h0, ~mHold});
    chk({ctx, ".addr"},   imemAddr,           mPc);
    chk({ctx, ".valid"},  {31'h0, ifIdValid}, {31'h0, mValid});
    chk({ctx, ".instr"},  ifIdInstr,          mInstr);
    chk({ctx, ".offset"}, {8'h0, ifIdOffset}, {8'h0, mInstr[23:0]});
    if (mValid || mHold) chk({ctx, ".ifpc"}, ifIdPc, mIfPc);
  endtask

  task automatic step(input string ctx, input logic rdy, input logic stl,
                      input logic br, input logic [31:0] tgt);
    imemReady = rdy; stall = stl; branchTaken = br; branchTarget = tgt;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(rdy, stl, br, tgt);
    #1;
    checkAll(ctx);
  endtask

  initial begin
    logic        r, s, b;
    logic [31:0] t;
    rst_n = 1'b0; imemReady = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
    modelReset();

    // Reset held for three cycles
    repeat (3) step("reset", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("w.reset_addr", wAddr, 32'hFFFF_FFFC);
    chk("w.reset_req", {31'h0, wReq}, 32'h0);

    rst_n = 1'b1;
    #1;
    chk("hold.req", {31'h0, imemReq}, 32'h0);
    chk("hold.wreq", {31'h0, wReq}, 32'h0);

    // Streaming
    step("stream0", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stream0.addr_c", imemAddr, 32'h0);
    chk("w.first_addr", wAddr, 32'hFFFF_FFFC);
    step("stream1", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stream1.ifpc_c", ifIdPc, 32'h8);
    chk("w.wrap_addr", wAddr, 32'h0);
    chk("w.wrap_ifpc", wPc, 32'h4);
    chk("w.wrap_instr", wInstr, 32'hFFFF_FFFC);
    chk("w.wrap_offset", {8'h0, wOffset}, 32'h00FF_FFFC);
    step("stream2", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stream2.addr_c", imemAddr, 32'h8);

    // Stall at 0x8 for two cycles
    step("stall0", 1'b1, 1'b1, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall.addr_c", imemAddr, 32'h8);
    chk("stall.ifpc_c", ifIdPc, 32'hC);
    step("unstall", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("unstall.instr_c", ifIdInstr, 32'hE000_0008);
    step("stream3", 1'b1, 1'b0, 1'b0, 32'h0);

    // Branch with ready memory at pc=0x10
    chk("br.pc_c", imemAddr, 32'h10);
    step("br_ready", 1'b1, 1'b0, 1'b1, 32'h100);
    chk("br_ready.addr_c", imemAddr, 32'h100);
    chk("br_ready.valid_c", {31'h0, ifIdValid}, 32'h0);
    step("br_next", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("br_next.ifpc_c", ifIdPc, 32'h108);

    // Branch during a memory wait
    step("to20", 1'b1, 1'b0, 1'b1, 32'h20);
    step("wait_br", 1'b0, 1'b0, 1'b1, 32'h200);
    step("wait1", 1'b0, 1'b0, 1'b0, 32'h0);
    step("wait2", 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wait.addr_c", imemAddr, 32'h20);
    step("wait_done", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wait_done.addr_c", imemAddr, 32'h200);
    chk("wait_done.valid_c", {31'h0, ifIdValid}, 32'h0);
    step("after200", 1'b1, 1'b0, 1'b0, 32'h0);

    // Second branch during drain overrides the first
    step("drain_br1", 1'b0, 1'b0, 1'b1, 32'h200);
    step("drain_br2", 1'b0, 1'b0, 1'b1, 32'h300);
    step("drain_w", 1'b0, 1'b0, 1'b0, 32'h0);
    step("drain_done", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drain_done.addr_c", imemAddr, 32'h300);
    step("drain_br3", 1'b0, 1'b0, 1'b1, 32'h400);
    step("drain_br4", 1'b1, 1'b0, 1'b1, 32'h500);
    chk("drain_same_cycle.addr_c", imemAddr, 32'h500);

    // Branch beats stall
    step("stall_br", 1'b1, 1'b1, 1'b1, 32'h600);
    chk("stall_br.addr_c", imemAddr, 32'h600);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      b = ($urandom_range(0, 9) < 1);
      case ($urandom_range(0, 3))
        0: t = 32'hFFFF_FFFC;
        1: t = 32'hFFFF_FFF8;
        default: t = $urandom;
      endcase
      step("rand", r, s, b, t);
      if (i == 200) begin
        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.req", {31'h0, imemReq}, 32'h0);
        chk("async.valid", {31'h0, ifIdValid}, 32'h0);
        chk("async.instr", ifIdInstr, 32'h0);
        chk("async.addr", imemAddr, 32'h0);
        chk("async.ifpc", ifIdPc, 32'h0);
        modelReset();
        step("async_hold", 1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
